back_propagation_hidden_2_scheduler: RTL and testbench

Sequencer for the hidden-2 back-propagation node (float32 multiplier followed by a 3-input pipelined accumulator). On each start it streams, for every hidden-1 neuron, the three hidden-2 deltas paired with their weights into the node. It then collects one accumulated error term per hidden-1 neuron and emits it with its neuron index. It sits between the weight memory/delta registers and the hidden-1 error writeback.

---
 rtl/back_propagation_hidden_2_scheduler_pkg.sv | 14 +
 rtl/back_propagation_hidden_2_scheduler_counter.sv | 26 ++
 rtl/back_propagation_hidden_2_scheduler.sv | 169 ++++++++++++++++
 tb/tb_back_propagation_hidden_2_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/back_propagation_hidden_2_scheduler_pkg.sv
// Shared definitions for the hidden-2 back-propagation scheduler.
// State encoding and accumulator fan-in.
package back_propagation_hidden_2_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_NODE = 3;

endpackage

// File: rtl/back_propagation_hidden_2_scheduler_counter.sv
// Wrap counter with clear, enable and terminal-count flag.
// Counts 0..MAX-1 and wraps; tc is high while count == MAX-1.
module back_propagation_scheduler_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == WIDTH'(MAX - 1));

    // Clear has priority over counting; wrap at the terminal count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/back_propagation_hidden_2_scheduler.sv
// Sequencer streaming delta/weight pairs into the hidden-2 node
// and collecting one accumulated error term per hidden-1 neuron.
module back_propagation_hidden_2_scheduler
    import back_propagation_hidden_2_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_OUT     = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int WADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [DATA_WIDTH-1:0]  i_delta_0,
    input  logic [DATA_WIDTH-1:0]  i_delta_1,
    input  logic [DATA_WIDTH-1:0]  i_delta_2,
    output logic [WADDR_WIDTH-1:0] o_weight_addr,
    output logic                   o_weight_rd,
    input  logic [DATA_WIDTH-1:0]  i_weight_data,
    output logic                   o_node_valid,
    output logic [DATA_WIDTH-1:0]  o_node_delta,
    output logic [DATA_WIDTH-1:0]  o_node_weight,
    input  logic                   i_node_valid,
    input  logic [DATA_WIDTH-1:0]  i_node_data,
    output logic                   o_err_valid,
    output logic [DATA_WIDTH-1:0]  o_err_data,
    output logic [ADDR_WIDTH-1:0]  o_err_addr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_spurious
);

    // rc must be able to hold NUM_OUT itself (run complete).
    localparam int RC_W = ADDR_WIDTH + 1;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  d0;
    logic [DATA_WIDTH-1:0]  d1;
    logic [DATA_WIDTH-1:0]  d2;
    logic [WADDR_WIDTH-1:0] ic;
    logic                   ic_tc;
    logic [1:0]             k;
    logic                   k_tc;
    logic [1:0]             k_d;
    logic [RC_W-1:0]        rc;
    logic                   rc_tc;
    logic                   start_ok;
    logic                   collecting;
    logic                   accept;
    logic                   last_accept;

    assign start_ok    = (state == IDLE) && i_start;
    assign collecting  = (state == ISSUE) || (state == DRAIN);
    assign accept      = collecting && i_node_valid && !rc_tc;
    assign last_accept = accept && (rc == RC_W'(NUM_OUT - 1));

    assign o_weight_addr = ic;
    assign o_node_weight = i_weight_data;

    back_propagation_scheduler_counter #(
        .WIDTH (WADDR_WIDTH),
        .MAX   (NUM_NODE * NUM_OUT)
    ) u_ic (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (o_weight_rd),
        .count (ic),
        .tc    (ic_tc)
    );

    back_propagation_scheduler_counter #(
        .WIDTH (2),
        .MAX   (NUM_NODE)
    ) u_k (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (o_weight_rd),
        .count (k),
        .tc    (k_tc)
    );

    back_propagation_scheduler_counter #(
        .WIDTH (RC_W),
        .MAX   (NUM_OUT + 1)
    ) u_rc (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (accept),
        .count (rc),
        .tc    (rc_tc)
    );

    // Delta operand follows the read by one cycle, like the weight.
    always_comb begin
        unique case (k_d)
            2'd1:    o_node_delta = d1;
            2'd2:    o_node_delta = d2;
            default: o_node_delta = d0;
        endcase
    end

    // Control FSM with registered outputs and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            d0           <= '0;
            d1           <= '0;
            d2           <= '0;
            k_d          <= '0;
            o_weight_rd  <= 1'b0;
            o_node_valid <= 1'b0;
            o_err_valid  <= 1'b0;
            o_err_data   <= '0;
            o_err_addr   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_spurious   <= 1'b0;
        end else begin
            k_d          <= k;
            o_node_valid <= o_weight_rd;
            o_err_valid  <= accept;
            o_done       <= 1'b0;
            if (accept) begin
                o_err_data <= i_node_data;
                o_err_addr <= rc[ADDR_WIDTH-1:0];
            end
            if (i_node_valid && !accept) begin
                o_spurious <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state       <= ISSUE;
                        d0          <= i_delta_0;
                        d1          <= i_delta_1;
                        d2          <= i_delta_2;
                        o_weight_rd <= 1'b1;
                        o_busy      <= 1'b1;
                        o_spurious  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (last_accept) begin
                        state       <= DONE;
                        o_weight_rd <= 1'b0;
                        o_done      <= 1'b1;
                    end else if (ic_tc && k_tc) begin
                        state       <= DRAIN;
                        o_weight_rd <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_back_propagation_hidden_2_scheduler.sv
// Bench for the hidden-2 back-propagation scheduler.
// Weight memory and node are behavioural models; results go through a scoreboard.
`timescale 1ns/1ps
module tb_back_propagation_hidden_2_scheduler;

    localparam int N = 4;

    typedef struct {
        int          due;
        logic [31:0] d;
    } pend_t;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        inj = 1'b0;
    logic [31:0] din0 = '0;
    logic [31:0] din1 = '0;
    logic [31:0] din2 = '0;

    logic [7:0]  wa, wa1;
    logic        wrd, wrd1;
    logic [31:0] wdata = '0;
    logic [31:0] wdata1 = '0;
    logic        nv, nv1;
    logic [31:0] nd, nd1, nw, nw1;
    logic        mv0 = 1'b0;
    logic        mv1 = 1'b0;
    logic [31:0] md0 = '0;
    logic [31:0] md1 = '0;
    logic        inv;
    logic        ev, ev1;
    logic [31:0] ed, ed1;
    logic [5:0]  ea, ea1;
    logic        busy, busy1, done, done1, spur, spur1;

    int passes = 0;
    int total = 0;
    int cyc = 0;
    int lat0 = 15;
    int lat1 = 1;
    int ndone0 = 0, nbusy0 = 0, nevrd0 = 0, ndone1 = 0;
    real acc0 = 0.0, acc1 = 0.0;
    int cnt0 = 0, cnt1 = 0;
    pend_t pq0[$];
    pend_t pq1[$];
    exp_t sb0[$];
    exp_t sb1[$];

    assign inv = mv0 | inj;

    back_propagation_hidden_2_scheduler #(
        .DATA_WIDTH(32), .NUM_OUT(N), .ADDR_WIDTH(6), .WADDR_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .i_start(start),
        .i_delta_0(din0), .i_delta_1(din1), .i_delta_2(din2),
        .o_weight_addr(wa), .o_weight_rd(wrd), .i_weight_data(wdata),
        .o_node_valid(nv), .o_node_delta(nd), .o_node_weight(nw),
        .i_node_valid(inv), .i_node_data(md0),
        .o_err_valid(ev), .o_err_data(ed), .o_err_addr(ea),
        .o_busy(busy), .o_done(done), .o_spurious(spur)
    );

    back_propagation_hidden_2_scheduler #(
        .DATA_WIDTH(32), .NUM_OUT(1), .ADDR_WIDTH(6), .WADDR_WIDTH(8)
    ) dut1 (
        .clk(clk), .rst(rst), .i_start(start1),
        .i_delta_0(din0), .i_delta_1(din1), .i_delta_2(din2),
        .o_weight_addr(wa1), .o_weight_rd(wrd1), .i_weight_data(wdata1),
        .o_node_valid(nv1), .o_node_delta(nd1), .o_node_weight(nw1),
        .i_node_valid(mv1), .i_node_data(md1),
        .o_err_valid(ev1), .o_err_data(ed1), .o_err_addr(ea1),
        .o_busy(busy1), .o_done(done1), .o_spurious(spur1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i2f(input int v);
        int msb;
        logic [31:0] m;
        if (v <= 0) return 32'h0;
        msb = 0;
        for (int i = 0; i < 31; i++) if (v[i]) msb = i;
        m = 32'(v) << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real m;
        int e;
        if (b[30:0] == 31'h0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        m = m * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (wrd) wdata <= i2f(int'(wa) + 1);
        if (wrd1) wdata1 <= i2f(int'(wa1) + 1);
    end

    // Node models: multiply, group by three, return after a latency.
    always @(negedge clk) begin
        pend_t p;
        mv0 = 1'b0;
        if (pq0.size() > 0 && pq0[0].due <= cyc) begin
            p = pq0.pop_front();
            mv0 = 1'b1;
            md0 = p.d;
        end
        if (rst) begin
            acc0 = 0.0;
            cnt0 = 0;
        end else if (nv) begin
            acc0 = acc0 + f2r(nd) * f2r(nw);
            cnt0++;
            if (cnt0 == 3) begin
                pq0.push_back('{cyc + lat0, i2f(int'(acc0))});
                acc0 = 0.0;
                cnt0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        pend_t p;
        mv1 = 1'b0;
        if (pq1.size() > 0 && pq1[0].due <= cyc) begin
            p = pq1.pop_front();
            mv1 = 1'b1;
            md1 = p.d;
        end
        if (rst) begin
            acc1 = 0.0;
            cnt1 = 0;
        end else if (nv1) begin
            acc1 = acc1 + f2r(nd1) * f2r(nw1);
            cnt1++;
            if (cnt1 == 3) begin
                pq1.push_back('{cyc + lat1, i2f(int'(acc1))});
                acc1 = 0.0;
                cnt1 = 0;
            end
        end
    end

    // Scoreboard monitors.
    always @(negedge clk) begin
        exp_t e;
        if (ev) begin
            if (sb0.size() == 0) begin
                chk("unexpected_err", 32'(ev), 32'd0);
            end else begin
                e = sb0.pop_front();
                chk("err_addr", 32'(ea), 32'(e.a));
                chk("err_data", ed, e.d);
            end
            if (wrd) nevrd0++;
        end
        if (done) ndone0++;
        if (busy) nbusy0++;
        if (ev1) begin
            if (sb1.size() == 0) begin
                chk("unexpected_err1", 32'(ev1), 32'd0);
            end else begin
                e = sb1.pop_front();
                chk("err_addr1", 32'(ea1), 32'(e.a));
                chk("err_data1", ed1, e.d);
            end
        end
        if (done1) ndone1++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_run(input int a, input int b, input int c);
        din0 = i2f(a);
        din1 = i2f(b);
        din2 = i2f(c);
        for (int j = 0; j < N; j++)
            sb0.push_back('{6'(j),
                i2f(a * (3*j+1) + b * (3*j+2) + c * (3*j+3))});
        ndone0 = 0;
        nbusy0 = 0;
        nevrd0 = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || sb0.size() > 0) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    initial begin
        int cs;
        int n;
        rst = 1'b1;
        tick();
        chk("rst_weight_rd", 32'(wrd), 32'd0);
        chk("rst_weight_addr", 32'(wa), 32'd0);
        chk("rst_node_valid", 32'(nv), 32'd0);
        chk("rst_err_valid", 32'(ev), 32'd0);
        chk("rst_err_addr", 32'(ea), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_spurious", 32'(spur), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Run 1: basic run with issue-pattern checks.
        start_run(1, 2, 3);
        for (int i = 0; i < 12; i++) begin
            chk("issue_rd", 32'(wrd), 32'd1);
            chk("issue_addr", 32'(wa), 32'(i));
            chk("issue_nv", 32'(nv), 32'(i > 0));
            if (i > 0) chk("issue_delta", nd, i2f(((i - 1) % 3) + 1));
            tick();
        end
        chk("issue_end_rd", 32'(wrd), 32'd0);
        chk("issue_end_nv", 32'(nv), 32'd1);
        chk("issue_end_delta", nd, i2f(3));
        wait_idle("run1_timeout");
        chk("run1_done_count", 32'(ndone0), 32'd1);
        chk("run1_busy_len", 32'(nbusy0), 32'(3*N + 2 + 15));

        // Run 2: start pulses while busy are ignored.
        tick();
        start_run(1, 2, 3);
        for (int c = 1; c <= 25; c++) begin
            start = (c == 5 || c == 20);
            din0 = start ? i2f(9) : i2f(1);
            din1 = start ? i2f(9) : i2f(2);
            din2 = start ? i2f(9) : i2f(3);
            tick();
        end
        start = 1'b0;
        wait_idle("run2_timeout");
        chk("run2_done_count", 32'(ndone0), 32'd1);
        for (int c = 0; c < 10; c++) tick();
        chk("run2_no_rerun", 32'(busy), 32'd0);
        chk("run2_done_total", 32'(ndone0), 32'd1);

        // Spurious result while idle.
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("spur_no_err", 32'(ev), 32'd0);
        chk("spur_set", 32'(spur), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        chk("spur_sticky", 32'(spur), 32'd1);

        // Run 3: reset in cycle 7 of a run.
        start_run(1, 2, 3);
        chk("spur_cleared", 32'(spur), 32'd0);
        for (int c = 1; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb0.delete();
        chk("mrst_weight_rd", 32'(wrd), 32'd0);
        chk("mrst_weight_addr", 32'(wa), 32'd0);
        chk("mrst_node_valid", 32'(nv), 32'd0);
        chk("mrst_node_delta", nd, 32'd0);
        chk("mrst_err_valid", 32'(ev), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_spurious", 32'(spur), 32'd0);
        n = 0;
        while (pq0.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("flush_timeout", 32'(n < 100), 32'd1);
        tick();
        tick();
        chk("late_spurious", 32'(spur), 32'd1);

        // Run 4: fresh run after reset.
        start_run(2, 1, 4);
        wait_idle("run4_timeout");
        chk("run4_done_count", 32'(ndone0), 32'd1);
        chk("run4_spurious", 32'(spur), 32'd0);

        // Run 5: fast node, results accepted during ISSUE.
        lat0 = 1;
        tick();
        start_run(1, 2, 3);
        wait_idle("run5_timeout");
        chk("run5_busy_len", 32'(nbusy0), 32'(3*N + 2 + 1));
        chk("run5_err_in_issue", 32'(nevrd0), 32'd3);

        // Run 6: NUM_OUT=1 with a fast node.
        din0 = i2f(1);
        din1 = i2f(2);
        din2 = i2f(3);
        sb1.push_back('{6'd0, i2f(14)});
        cs = cyc;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 50) begin
            tick();
            n++;
        end
        chk("n1_done_cycle", 32'(cyc - cs), 32'd6);
        tick();
        chk("n1_idle", 32'(busy1), 32'd0);
        chk("n1_done_count", 32'(ndone1), 32'd1);
        chk("n1_results", 32'(sb1.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
